// File: rtl/alu_pkg.sv
// Shared ALU definitions: mode encodings, sequencer state encoding and the
// per-mode initial carry/borrow helper.
package alu_pkg;

  localparam logic [2:0] MODE_ADD = 3'b000;
  localparam logic [2:0] MODE_SUB = 3'b001;
  localparam logic [2:0] MODE_AND = 3'b010;
  localparam logic [2:0] MODE_OR  = 3'b011;
  localparam logic [2:0] MODE_XOR = 3'b100;
  localparam logic [2:0] MODE_NOT = 3'b101;
  localparam logic [2:0] MODE_INC = 3'b110;
  localparam logic [2:0] MODE_DEC = 3'b111;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  // INC/DEC are ADD/SUB of a forced carry/borrow into the lowest word.
  function automatic logic init_cb(logic [2:0] mode, logic cin);
    case (mode)
      MODE_ADD, MODE_SUB: return cin;
      MODE_INC, MODE_DEC: return 1'b1;
      default:            return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_wide_seq_if.sv
// Operand/command and result handshake bundle for the word-serial ALU sequencer.
interface alu_wide_seq_if #(
  parameter int unsigned N     = 3,
  parameter int unsigned WORDS = 4
);
  localparam int unsigned W = N * WORDS;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic [2:0]   mode;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] res;
  logic         cout;

  modport master (
    output in_valid, a, b, cin, mode, out_ready,
    input  in_ready, out_valid, res, cout
  );

  modport slave (
    input  in_valid, a, b, cin, mode, out_ready,
    output in_ready, out_valid, res, cout
  );
endinterface

// File: rtl/alu_slice.sv
// Combinational N-bit ALU slice with carry/borrow in and out.
module alu_slice import alu_pkg::*; #(
  parameter int unsigned N = 3
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic         cb_in,
  input  logic [2:0]   mode,
  output logic [N-1:0] r,
  output logic         cb_out
);

  logic [N:0] w_ext;
  logic [N:0] w_cb;

  assign w_cb = {{N{1'b0}}, cb_in};

  // Bit N carries carry-out or borrow-out; logic modes keep it zero.
  always_comb begin
    w_ext = '0;
    case (mode)
      MODE_ADD: w_ext = {1'b0, a_i} + {1'b0, b_i} + w_cb;
      MODE_SUB: w_ext = {1'b0, a_i} - {1'b0, b_i} - w_cb;
      MODE_AND: w_ext = {1'b0, a_i & b_i};
      MODE_OR:  w_ext = {1'b0, a_i | b_i};
      MODE_XOR: w_ext = {1'b0, a_i ^ b_i};
      MODE_NOT: w_ext = {1'b0, ~a_i};
      MODE_INC: w_ext = {1'b0, a_i} + w_cb;
      MODE_DEC: w_ext = {1'b0, a_i} - w_cb;
      default:  w_ext = '0;
    endcase
  end

  assign r      = w_ext[N-1:0];
  assign cb_out = w_ext[N];

endmodule

// File: rtl/alu_wide_seq.sv
// Word-serial multi-precision ALU: runs one N-bit slice WORDS times per
// operation, chaining carry/borrow from the least-significant word upward.
module alu_wide_seq import alu_pkg::*; #(
  parameter int unsigned N     = 3,
  parameter int unsigned WORDS = 4
) (
  input logic           clk,
  input logic           rst,
  alu_wide_seq_if.slave bus
);

  localparam int unsigned W    = N * WORDS;
  localparam int unsigned IdxW = (WORDS > 1) ? $clog2(WORDS) : 1;

  state_e          r_state;
  logic [IdxW-1:0] r_idx;
  logic            r_cb;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic [2:0]      r_mode;
  logic [W-1:0]    r_res;
  logic            r_cout;
  logic            r_in_ready;
  logic            r_out_valid;

  logic [N-1:0]    w_r;
  logic            w_cb_out;
  logic            w_last;

  alu_slice #(
    .N (N)
  ) u_slice (
    .a_i    (r_a[r_idx*N +: N]),
    .b_i    (r_b[r_idx*N +: N]),
    .cb_in  (r_cb),
    .mode   (r_mode),
    .r      (w_r),
    .cb_out (w_cb_out)
  );

  assign w_last = (r_idx == IdxW'(WORDS - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= StIdle;
      r_idx       <= '0;
      r_cb        <= 1'b0;
      r_a         <= '0;
      r_b         <= '0;
      r_mode      <= MODE_ADD;
      r_res       <= '0;
      r_cout      <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          if (bus.in_valid) begin
            r_a        <= bus.a;
            r_b        <= bus.b;
            r_mode     <= bus.mode;
            r_idx      <= '0;
            r_cb       <= init_cb(bus.mode, bus.cin);
            r_in_ready <= 1'b0;
            r_state    <= StRun;
          end
        end
        StRun: begin
          r_res[r_idx*N +: N] <= w_r;
          r_cb                <= w_cb_out;
          r_idx               <= r_idx + 1'b1;
          // The slice already drives cb_out low for logic modes.
          if (w_last) begin
            r_cout      <= w_cb_out;
            r_out_valid <= 1'b1;
            r_state     <= StDone;
          end
        end
        StDone: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= StIdle;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= StIdle;
        end
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.res       = r_res;
  assign bus.cout      = r_cout;

endmodule

// File: tb/tb_alu_wide_seq.sv
// Directed and random checks of alu_wide_seq against a full-width arithmetic model.
module tb_alu_wide_seq;
  import alu_pkg::*;

  localparam int unsigned N     = 3;
  localparam int unsigned WORDS = 4;
  localparam int unsigned W     = N * WORDS;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  alu_wide_seq_if #(.N(N), .WORDS(WORDS)) bus ();

  alu_wide_seq #(
    .N     (N),
    .WORDS (WORDS)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Full-width reference: plain integer arithmetic on the whole operands.
  function automatic void model(input logic [2:0] mode, input int a, input int b, input int cin,
                                output logic [W-1:0] r, output logic c);
    int full = 1 << W;
    int v;
    c = 1'b0;
    case (mode)
      MODE_ADD: begin v = a + b + cin; c = (v >= full); end
      MODE_SUB: begin v = a - b - cin; c = (a < b + cin); end
      MODE_AND: v = a & b;
      MODE_OR:  v = a | b;
      MODE_XOR: v = a ^ b;
      MODE_NOT: v = ~a;
      MODE_INC: begin v = a + 1; c = (a == full - 1); end
      default:  begin v = a - 1; c = (a == 0); end
    endcase
    r = W'((v % full + full) % full);
  endfunction

  task automatic start(input logic [2:0] mode, input int a, input int b, input int cin);
    int n = 0;
    while (!bus.in_ready && n < 20) begin tick(); n++; end
    check("in_ready_before_accept", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.mode     = mode;
    bus.a        = W'(a);
    bus.b        = W'(b);
    bus.cin      = cin[0];
    tick();
    bus.in_valid = 1'b0;
    bus.a        = W'($urandom);
    bus.b        = W'($urandom);
    bus.cin      = 1'($urandom);
    bus.mode     = 3'($urandom);
  endtask

  // Called in cycle T+1; returns in cycle T+WORDS+1 (first DONE cycle).
  task automatic run_phase(input string tag);
    for (int k = 0; k < int'(WORDS); k++) begin
      check({tag, "_run_out_valid"}, 32'(bus.out_valid), 32'd0);
      check({tag, "_run_in_ready"}, 32'(bus.in_ready), 32'd0);
      tick();
    end
    check({tag, "_done_out_valid"}, 32'(bus.out_valid), 32'd1);
    check({tag, "_done_in_ready"}, 32'(bus.in_ready), 32'd0);
  endtask

  task automatic expect_result(input string tag, input logic [2:0] mode, input int a,
                               input int b, input int cin);
    logic [W-1:0] er;
    logic         ec;
    model(mode, a, b, cin, er, ec);
    check({tag, "_res"}, 32'(bus.res), 32'(er));
    check({tag, "_cout"}, 32'(bus.cout), 32'(ec));
  endtask

  task automatic op(input string tag, input logic [2:0] mode, input int a, input int b,
                    input int cin);
    start(mode, a, b, cin);
    run_phase(tag);
    expect_result(tag, mode, a, b, cin);
    tick();
    check({tag, "_idle_in_ready"}, 32'(bus.in_ready), 32'd1);
    check({tag, "_idle_out_valid"}, 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    logic [W-1:0] held_res;
    logic         held_cout;
    int           seen_valid;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.a         = '0;
    bus.b         = '0;
    bus.cin       = 1'b0;
    bus.mode      = MODE_ADD;
    tick();
    tick();
    rst = 1'b0;
    check("reset_in_ready", 32'(bus.in_ready), 32'd1);
    check("reset_out_valid", 32'(bus.out_valid), 32'd0);
    check("reset_res", 32'(bus.res), 32'd0);
    check("reset_cout", 32'(bus.cout), 32'd0);

    op("add_wrap", MODE_ADD, 'hFFF, 'h001, 0);
    op("sub_a", MODE_SUB, 'h100, 'h001, 0);
    op("sub_b", MODE_SUB, 'h000, 'h001, 0);
    op("sub_c", MODE_SUB, 'h005, 'h002, 1);
    op("inc_a", MODE_INC, 'h7FF, 'h000, 0);
    op("inc_b", MODE_INC, 'hFFF, 'h000, 0);
    op("dec_a", MODE_DEC, 'h000, 'h000, 0);
    op("xor_a", MODE_XOR, 'hA5A, 'hFFF, 1);
    op("not_a", MODE_NOT, 'h0F0, 'h000, 0);
    op("and_a", MODE_AND, 'hC3C, 'h0FF, 0);
    op("or_a", MODE_OR, 'h805, 'h030, 1);
    op("dec_b", MODE_DEC, 'h800, 'h000, 1);

    // Backpressure: result held while a new command is offered and refused.
    bus.out_ready = 1'b0;
    start(MODE_ADD, 'h123, 'h456, 1);
    run_phase("bp");
    expect_result("bp", MODE_ADD, 'h123, 'h456, 1);
    held_res     = bus.res;
    held_cout    = bus.cout;
    bus.in_valid = 1'b1;
    bus.mode     = MODE_SUB;
    bus.a        = W'('h010);
    bus.b        = W'('h020);
    bus.cin      = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("bp_hold_out_valid", 32'(bus.out_valid), 32'd1);
      check("bp_hold_in_ready", 32'(bus.in_ready), 32'd0);
      check("bp_hold_res", 32'(bus.res), 32'(held_res));
      check("bp_hold_cout", 32'(bus.cout), 32'(held_cout));
    end
    bus.out_ready = 1'b1;
    tick();
    check("bp_idle_in_ready", 32'(bus.in_ready), 32'd1);
    check("bp_idle_out_valid", 32'(bus.out_valid), 32'd0);
    tick();
    bus.in_valid = 1'b0;
    run_phase("bp_next");
    expect_result("bp_next", MODE_SUB, 'h010, 'h020, 0);
    tick();

    // Reset during the second RUN cycle discards the operation.
    start(MODE_ADD, 'h777, 'h111, 0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_in_ready", 32'(bus.in_ready), 32'd1);
    check("abort_out_valid", 32'(bus.out_valid), 32'd0);
    check("abort_res", 32'(bus.res), 32'd0);
    check("abort_cout", 32'(bus.cout), 32'd0);
    seen_valid = 0;
    for (int k = 0; k < 8; k++) begin
      if (bus.out_valid) seen_valid++;
      tick();
    end
    check("abort_no_result", 32'(seen_valid), 32'd0);
    op("after_abort", MODE_ADD, 'h001, 'h001, 0);

    for (int k = 0; k < 40; k++) begin
      op("rand", 3'($urandom), int'($urandom_range(4095, 0)), int'($urandom_range(4095, 0)),
         int'($urandom_range(1, 0)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
